// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared widths, funct3 codes, FSM states and access sizing for mem_access
package mem_access_pkg;

  localparam int REG_BUS = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_BUSY = 1'b1
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  // Unlisted funct3 codes fall through to a word access for both loads and stores.
  function automatic mem_size_e access_size(input logic is_store, input logic [2:0] funct3);
    mem_size_e sz;
    sz = SZ_WORD;
    if (is_store) begin
      case (funct3)
        F3_LB:   sz = SZ_BYTE;
        F3_LH:   sz = SZ_HALF;
        default: sz = SZ_WORD;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LBU: sz = SZ_BYTE;
        F3_LH, F3_LHU: sz = SZ_HALF;
        default:       sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// rtl/mem_load_ext.sv - selects the addressed byte/half of a read word and sign- or zero-extends it
module mem_load_ext
  import mem_access_pkg::*;
(
  input  logic [REG_BUS-1:0] rdata_i,
  input  logic [1:0]         addr_lo_i,
  input  logic [2:0]         funct3_i,
  output logic [REG_BUS-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data_o = {24'b0, byte_sel};
      F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data_o = {16'b0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM stage: issues one data-memory access at a time and registers MEM/WB outputs
module mem_access
  import mem_access_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  input  logic               ctrl_mem_read_i,
  input  logic               ctrl_mem_write_i,
  input  logic [2:0]         mem_funct3_i,
  input  logic [REG_BUS-1:0] alu_result_i,
  input  logic [REG_BUS-1:0] store_data_i,
  input  logic               ctrl_wb_Mem2Reg_i,
  input  logic               ctrl_wb_RegWrite_i,
  input  logic [4:0]         rd_i,
  output logic               dmem_req_o,
  output logic               dmem_we_o,
  output logic [REG_BUS-1:0] dmem_addr_o,
  output logic [3:0]         dmem_be_o,
  output logic [REG_BUS-1:0] dmem_wdata_o,
  input  logic               dmem_ack_i,
  input  logic [REG_BUS-1:0] dmem_rdata_i,
  output logic               stall_o,
  output logic               valid_o,
  output logic [REG_BUS-1:0] mem_read_data_o,
  output logic [REG_BUS-1:0] alu_result_o,
  output logic               ctrl_wb_Mem2Reg_o,
  output logic               ctrl_wb_RegWrite_o,
  output logic [4:0]         rd_o,
  output logic               misalign_o
);

  mem_state_e         state_q, state_d;
  logic               req_q, req_d, we_q, we_d;
  logic [REG_BUS-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic               valid_q, valid_d, misalign_q, misalign_d;
  logic [REG_BUS-1:0] rdata_q, rdata_d, alu_q, alu_d;
  logic               m2r_q, m2r_d, rw_q, rw_d;
  logic [4:0]         rd_q, rd_d;

  logic               mem_op, is_store, misaligned;
  mem_size_e          size;
  logic [3:0]         be_lane;
  logic [REG_BUS-1:0] wdata_lane, load_data;

  // A simultaneous read+write request is resolved as a store.
  assign mem_op   = ctrl_mem_read_i | ctrl_mem_write_i;
  assign is_store = ctrl_mem_write_i;
  assign size     = access_size(is_store, mem_funct3_i);
  assign misaligned = mem_op &
                      (((size == SZ_HALF) & alu_result_i[0]) |
                       ((size == SZ_WORD) & (alu_result_i[1:0] != 2'b00)));

  always_comb begin
    be_lane    = 4'b1111;
    wdata_lane = store_data_i;
    case (size)
      SZ_BYTE: begin
        be_lane    = 4'b0001 << alu_result_i[1:0];
        wdata_lane = {4{store_data_i[7:0]}};
      end
      SZ_HALF: begin
        be_lane    = alu_result_i[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  mem_load_ext u_load_ext (
    .rdata_i   (dmem_rdata_i),
    .addr_lo_i (alu_result_i[1:0]),
    .funct3_i  (mem_funct3_i),
    .data_o    (load_data)
  );

  // Upstream holds the instruction stable through BUSY, so the ack cycle still sees its fields.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    valid_d    = 1'b0;
    misalign_d = 1'b0;
    rdata_d    = rdata_q;
    alu_d      = alu_q;
    m2r_d      = m2r_q;
    rw_d       = rw_q;
    rd_d       = rd_q;
    stall_o    = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (valid_i) begin
          if (mem_op && !misaligned) begin
            stall_o = 1'b1;
            state_d = MEM_BUSY;
            req_d   = 1'b1;
            we_d    = is_store;
            addr_d  = {alu_result_i[REG_BUS-1:2], 2'b00};
            be_d    = be_lane;
            wdata_d = wdata_lane;
          end else begin
            valid_d    = 1'b1;
            misalign_d = misaligned;
            rdata_d    = '0;
            alu_d      = alu_result_i;
            m2r_d      = ctrl_wb_Mem2Reg_i;
            rw_d       = ctrl_wb_RegWrite_i & ~misaligned;
            rd_d       = rd_i;
          end
        end
      end
      MEM_BUSY: begin
        if (dmem_ack_i) begin
          state_d = MEM_IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          be_d    = '0;
          wdata_d = '0;
          valid_d = 1'b1;
          rdata_d = is_store ? '0 : load_data;
          alu_d   = alu_result_i;
          m2r_d   = ctrl_wb_Mem2Reg_i;
          rw_d    = ctrl_wb_RegWrite_i;
          rd_d    = rd_i;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MEM_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      rdata_q    <= '0;
      alu_q      <= '0;
      m2r_q      <= 1'b0;
      rw_q       <= 1'b0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      rdata_q    <= rdata_d;
      alu_q      <= alu_d;
      m2r_q      <= m2r_d;
      rw_q       <= rw_d;
      rd_q       <= rd_d;
    end
  end

  assign dmem_req_o         = req_q;
  assign dmem_we_o          = we_q;
  assign dmem_addr_o        = addr_q;
  assign dmem_be_o          = be_q;
  assign dmem_wdata_o       = wdata_q;
  assign valid_o            = valid_q;
  assign misalign_o         = misalign_q;
  assign mem_read_data_o    = rdata_q;
  assign alu_result_o       = alu_q;
  assign ctrl_wb_Mem2Reg_o  = m2r_q;
  assign ctrl_wb_RegWrite_o = rw_q;
  assign rd_o               = rd_q;

endmodule
